// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with variable-latency memory handshake,
// illegal-opcode and memory-timeout traps, and a retired-instruction counter.
module legv8_multicycle_control #(
  parameter int unsigned OPCODE_W    = 11,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [OPCODE_W-1:0] instr_i,
  input  logic                mem_ready_i,
  input  logic                zero_i,
  output logic                reg2loc_o,
  output logic                alu_src_o,
  output logic                mem_to_reg_o,
  output logic                reg_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                pc_src_o,
  output logic [1:0]          alu_op_o,
  output logic                busy_o,
  output logic                illegal_o,
  output logic                mem_fault_o,
  output logic [CNT_W-1:0]    retired_o
);

  localparam int unsigned TmoW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StTrap} state_e;
  typedef enum logic [2:0] {ClsIllegal, ClsR, ClsLdur, ClsStur, ClsCbz, ClsCbnz, ClsB} cls_e;

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                illegal_q, illegal_d;
  logic                mem_fault_q, mem_fault_d;
  logic                retire;
  logic [10:0]         op_top;
  cls_e                cls;

  assign op_top = opcode_q[OPCODE_W-1 -: 11];

  always_comb begin
    cls = ClsIllegal;
    casez (op_top)
      11'b1??0101?000: cls = ClsR;
      11'b11111000010: cls = ClsLdur;
      11'b11111000000: cls = ClsStur;
      11'b10110100???: cls = ClsCbz;
      11'b10110101???: cls = ClsCbnz;
      11'b000101?????: cls = ClsB;
      default:         cls = ClsIllegal;
    endcase
  end

  // Timeout counter defaults to clear; it only counts while waiting in FETCH or MEM.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    tmo_d       = '0;
    illegal_d   = illegal_q;
    mem_fault_d = mem_fault_q;
    retire      = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (mem_ready_i) begin
          opcode_d = instr_i;
          state_d  = StDecode;
        end else if (tmo_q == TmoLast) begin
          state_d     = StTrap;
          mem_fault_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDecode: begin
        if (cls == ClsIllegal) begin
          state_d   = StTrap;
          illegal_d = 1'b1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls)
          ClsR:             state_d = StWb;
          ClsLdur, ClsStur: state_d = StMem;
          ClsCbz, ClsCbnz, ClsB: begin
            retire  = 1'b1;
            state_d = StFetch;
          end
          default:          state_d = StTrap;
        endcase
      end
      StMem: begin
        if (mem_ready_i) begin
          if (cls == ClsLdur) begin
            state_d = StWb;
          end else begin
            retire  = 1'b1;
            state_d = StFetch;
          end
        end else if (tmo_q == TmoLast) begin
          state_d     = StTrap;
          mem_fault_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StFetch;
      opcode_q    <= '0;
      tmo_q       <= '0;
      retired_q   <= '0;
      illegal_q   <= 1'b0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      tmo_q       <= tmo_d;
      retired_q   <= retired_d;
      illegal_q   <= illegal_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // Controls decode from state and latched class; reset forces everything low at once.
  always_comb begin
    reg2loc_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    alu_op_o     = 2'b00;
    busy_o       = 1'b0;
    if (!reset_i) begin
      unique case (state_q)
        StFetch: begin
          busy_o     = 1'b1;
          mem_read_o = 1'b1;
          ir_write_o = mem_ready_i;
          pc_write_o = mem_ready_i;
        end
        StDecode: busy_o = 1'b1;
        StExec: begin
          busy_o = 1'b1;
          case (cls)
            ClsR:             alu_op_o = 2'b10;
            ClsLdur, ClsStur: alu_src_o = 1'b1;
            ClsCbz, ClsCbnz: begin
              reg2loc_o  = 1'b1;
              alu_op_o   = 2'b01;
              pc_src_o   = 1'b1;
              pc_write_o = (cls == ClsCbz) ? zero_i : ~zero_i;
            end
            ClsB: begin
              pc_src_o   = 1'b1;
              pc_write_o = 1'b1;
            end
            default: ;
          endcase
        end
        StMem: begin
          busy_o      = 1'b1;
          alu_src_o   = 1'b1;
          mem_read_o  = (cls == ClsLdur);
          mem_write_o = (cls == ClsStur);
        end
        StWb: begin
          busy_o       = 1'b1;
          reg_write_o  = 1'b1;
          mem_to_reg_o = (cls == ClsLdur);
        end
        StTrap:  ;
        default: ;
      endcase
    end
  end

  assign illegal_o   = illegal_q & ~reset_i;
  assign mem_fault_o = mem_fault_q & ~reset_i;
  assign retired_o   = reset_i ? '0 : retired_q;

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Randomized scoreboard bench: each issued instruction pushes its expected per-instruction
// activity (cycle count, enable-cycle counts, end status); a negedge monitor closes and checks windows.
module tb_legv8_multicycle_control;

  localparam int Tmo  = 4;
  localparam int CntW = 4;

  localparam int KR = 0, KLdur = 1, KStur = 2, KCbz = 3, KCbnz = 4, KB = 5, KIll = 6;
  localparam int KFTmo = 7, KMTmoL = 8, KMTmoS = 9, KAbort = 10;

  logic            clk = 1'b0;
  logic            reset, mem_ready, zero;
  logic [10:0]     instr;
  logic            reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
  logic            ir_write, pc_write, pc_src, busy, illegal, mem_fault;
  logic [1:0]      alu_op;
  logic [CntW-1:0] retired;

  legv8_multicycle_control #(
    .OPCODE_W   (11),
    .MEM_TIMEOUT(Tmo),
    .CNT_W      (CntW)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .instr_i     (instr),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .reg2loc_o   (reg2loc),
    .alu_src_o   (alu_src),
    .mem_to_reg_o(mem_to_reg),
    .reg_write_o (reg_write),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .ir_write_o  (ir_write),
    .pc_write_o  (pc_write),
    .pc_src_o    (pc_src),
    .alu_op_o    (alu_op),
    .busy_o      (busy),
    .illegal_o   (illegal),
    .mem_fault_o (mem_fault),
    .retired_o   (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int trap;
    int cycles, rd, wr, rw, pcw, irw, m2r, asrc, r2l, pcsrc, op10, op01;
    int ret, ill, flt;
  } exp_t;

  exp_t sb_q[$];
  exp_t win;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;
  int   last_ret = 0;
  bit   in_trap  = 1'b0;

  task automatic check(string name, int act, int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Expected activity of one instruction, counted straight from the per-state rules.
  function automatic exp_t model(int kind, int fw, int mw, bit z);
    exp_t e = '{default: 0};
    e.irw = 1;
    e.pcw = 1;
    e.rd  = fw + 1;
    case (kind)
      KR: begin
        e.cycles = fw + 4; e.rw = 1; e.op10 = 1;
      end
      KLdur: begin
        e.cycles = fw + mw + 5; e.rd = fw + mw + 2; e.rw = 1; e.m2r = 1; e.asrc = mw + 2;
      end
      KStur: begin
        e.cycles = fw + mw + 4; e.wr = mw + 1; e.asrc = mw + 2;
      end
      KCbz, KCbnz: begin
        e.cycles = fw + 3; e.r2l = 1; e.pcsrc = 1; e.op01 = 1;
        e.pcw = 1 + ((kind == KCbz) ? int'(z) : int'(!z));
      end
      KB: begin
        e.cycles = fw + 3; e.pcw = 2; e.pcsrc = 1;
      end
      KIll: begin
        e.trap = 1; e.cycles = fw + 2; e.ill = 1;
      end
      KFTmo: begin
        e.trap = 1; e.cycles = Tmo; e.rd = Tmo; e.irw = 0; e.pcw = 0; e.flt = 1;
      end
      default: begin
        e.trap = 1; e.cycles = fw + 3 + Tmo; e.asrc = 1 + Tmo; e.flt = 1;
        if (kind == KMTmoL) e.rd = fw + 1 + Tmo;
        else e.wr = Tmo;
      end
    endcase
    return e;
  endfunction

  function automatic bit is_legal(logic [10:0] o);
    return (o ==? 11'b1??0101?000) || (o == 11'b11111000010) || (o == 11'b11111000000) ||
           (o ==? 11'b10110100???) || (o ==? 11'b10110101???) || (o ==? 11'b000101?????);
  endfunction

  function automatic logic [10:0] make_op(int kind);
    logic [10:0] o = 11'($urandom);
    case (kind)
      KR: begin o[10] = 1'b1; o[7:4] = 4'b0101; o[2:0] = 3'b000; end
      KLdur, KMTmoL, KAbort: o = 11'b11111000010;
      KStur, KMTmoS:         o = 11'b11111000000;
      KCbz:  o = {8'b10110100, o[2:0]};
      KCbnz: o = {8'b10110101, o[2:0]};
      KB:    o = {6'b000101, o[4:0]};
      KIll: begin
        for (int i = 0; i < 64 && is_legal(o); i++) o = 11'($urandom);
        if (is_legal(o)) o = 11'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Monitor: a window closes on a retired change (current sample starts the next one) or on busy=0.
  task automatic close_win(int trap);
    exp_t e;
    check("sb_nonempty", int'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("end_kind", trap, e.trap);
      check("cycles", win.cycles, e.cycles);
      check("mem_read_cyc", win.rd, e.rd);
      check("mem_write_cyc", win.wr, e.wr);
      check("reg_write_cyc", win.rw, e.rw);
      check("pc_write_cyc", win.pcw, e.pcw);
      check("ir_write_cyc", win.irw, e.irw);
      check("mem_to_reg_cyc", win.m2r, e.m2r);
      check("alu_src_cyc", win.asrc, e.asrc);
      check("reg2loc_cyc", win.r2l, e.r2l);
      check("pc_src_cyc", win.pcsrc, e.pcsrc);
      check("alu_op10_cyc", win.op10, e.op10);
      check("alu_op01_cyc", win.op01, e.op01);
      if (trap == 0) check("retired", int'(retired), e.ret);
      check("illegal", int'(illegal), e.ill);
      check("mem_fault", int'(mem_fault), e.flt);
    end
    win = '{default: 0};
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("reset_outputs", int'({reg2loc, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
                                   ir_write, pc_write, pc_src, alu_op, busy, illegal, mem_fault,
                                   retired}), 0);
      win      = '{default: 0};
      last_ret = 0;
      in_trap  = 1'b0;
    end else if (in_trap) begin
      check("trap_hold", int'({busy, mem_read, mem_write, reg_write, ir_write, pc_write}), 0);
    end else begin
      if (int'(retired) != last_ret) begin
        close_win(0);
        last_ret = int'(retired);
      end else if (!busy) begin
        close_win(1);
        in_trap = 1'b1;
      end
      if (!in_trap) begin
        win.cycles++;
        win.rd    += int'(mem_read);
        win.wr    += int'(mem_write);
        win.rw    += int'(reg_write);
        win.pcw   += int'(pc_write);
        win.irw   += int'(ir_write);
        win.m2r   += int'(mem_to_reg);
        win.asrc  += int'(alu_src);
        win.r2l   += int'(reg2loc);
        win.pcsrc += int'(pc_src);
        win.op10  += int'(alu_op == 2'b10);
        win.op01  += int'(alu_op == 2'b01);
      end
    end
  end

  task automatic step(bit r, logic [10:0] op, bit z, bit rst);
    mem_ready = r;
    instr     = op;
    zero      = z;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] junk();
    return 11'($urandom);
  endfunction

  task automatic do_reset();
    step(rb(), junk(), rb(), 1'b1);
    step(rb(), junk(), rb(), 1'b1);
    exp_cnt = 0;
  endtask

  task automatic trap_tail();
    repeat (3) step(rb(), junk(), rb(), 1'b0);
    do_reset();
  endtask

  task automatic run_op(int kind, logic [10:0] op, int fw, int mw, bit z);
    exp_t e = model(kind, fw, mw, z);
    if (e.trap == 0 && kind != KAbort) begin
      exp_cnt++;
      e.ret = exp_cnt % (1 << CntW);
    end
    if (kind != KAbort) sb_q.push_back(e);
    if (kind == KFTmo) begin
      repeat (Tmo) step(1'b0, junk(), rb(), 1'b0);
      trap_tail();
      return;
    end
    repeat (fw) step(1'b0, junk(), rb(), 1'b0);
    step(1'b1, op, rb(), 1'b0);
    step(rb(), junk(), rb(), 1'b0);
    if (kind == KIll) begin
      trap_tail();
      return;
    end
    step(rb(), junk(), z, 1'b0);
    case (kind)
      KR: step(rb(), junk(), rb(), 1'b0);
      KLdur, KStur: begin
        repeat (mw) step(1'b0, junk(), rb(), 1'b0);
        step(1'b1, junk(), rb(), 1'b0);
        if (kind == KLdur) step(rb(), junk(), rb(), 1'b0);
      end
      KMTmoL, KMTmoS: begin
        repeat (Tmo) step(1'b0, junk(), rb(), 1'b0);
        trap_tail();
      end
      KAbort: begin
        step(1'b0, junk(), rb(), 1'b0);
        do_reset();
      end
      default: ;
    endcase
  endtask

  task automatic run(int kind, int fw, int mw, bit z);
    run_op(kind, make_op(kind), fw, mw, z);
  endtask

  function automatic int pick_kind(bit legal_only);
    int r = legal_only ? $urandom_range(0, 77) : $urandom_range(0, 99);
    if (r < 14) return KR;
    if (r < 28) return KLdur;
    if (r < 42) return KStur;
    if (r < 54) return KCbz;
    if (r < 66) return KCbnz;
    if (r < 78) return KB;
    if (r < 84) return KIll;
    if (r < 88) return KFTmo;
    if (r < 92) return KMTmoL;
    if (r < 96) return KMTmoS;
    return KAbort;
  endfunction

  initial begin
    win = '{default: 0};
    do_reset();
    run_op(KR, 11'b10001011000, 0, 0, 1'b0);
    run(KLdur, 0, 3, 1'b0);
    run(KCbz, 0, 0, 1'b1);
    run(KCbnz, 0, 0, 1'b1);
    run(KB, 0, 0, 1'b0);
    run(KStur, 1, 2, 1'b0);
    run(KR, 3, 0, 1'b0);
    run_op(KIll, 11'b00000000000, 0, 0, 1'b0);
    run(KFTmo, 0, 0, 1'b0);
    run(KMTmoL, 1, 0, 1'b0);
    run(KAbort, 0, 0, 1'b0);
    // Long legal stretch so the narrow retired counter wraps.
    repeat (22) run(pick_kind(1'b1), $urandom_range(0, Tmo - 1), $urandom_range(0, Tmo - 1), rb());
    repeat (100) run(pick_kind(1'b0), $urandom_range(0, Tmo - 1), $urandom_range(0, Tmo - 1), rb());
    step(1'b0, junk(), 1'b0, 1'b0);
    step(1'b0, junk(), 1'b0, 1'b0);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
